// File: rtl/exec_alu_fu_pkg.sv
// Shared op encoding and width defaults for the integer FU and the reservation station.
// Define MUL_ENABLE_EN to build the iterative multiplier state.
package exec_alu_fu_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int ROB_W_DEF  = 6;
    localparam int PREG_W_DEF = 6;

    typedef enum logic [3:0] {
        FU_ADD  = 4'd0,
        FU_SUB  = 4'd1,
        FU_AND  = 4'd2,
        FU_OR   = 4'd3,
        FU_XOR  = 4'd4,
        FU_SLL  = 4'd5,
        FU_SRL  = 4'd6,
        FU_SRA  = 4'd7,
        FU_SLT  = 4'd8,
        FU_SLTU = 4'd9,
        FU_MUL  = 4'd10
    } fu_op_t;

`ifdef MUL_ENABLE_EN
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_BUSY = 2'd1,
        ST_DONE     = 2'd2
    } fu_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DONE = 2'd2
    } fu_state_t;
`endif

endpackage

// File: rtl/exec_alu_fu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per edge, XLEN steps, low XLEN bits kept.
// done/product are valid combinationally during the final step so the owner can capture on that edge.
module mul_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            clear,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int CW = $clog2(XLEN);

    logic            busy;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] partial;

    assign partial = mplier[0] ? mcand : '0;
    assign product = acc + partial;
    assign done    = busy && (cnt == CW'(XLEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy   <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (clear) begin
            busy <= 1'b0;
            cnt  <= '0;
            acc  <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (done) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/exec_alu_fu.sv
// Integer FU at the RS issue port: executes one op, holds the result until the CDB grants it.
// Optional iterative MUL is built when MUL_ENABLE_EN is defined.
module exec_alu_fu
    import exec_alu_fu_pkg::*;
#(
    parameter int ROB_W  = ROB_W_DEF,
    parameter int PREG_W = PREG_W_DEF,
    parameter int XLEN   = XLEN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [3:0]        issue_op,
    input  logic [ROB_W-1:0]  issue_rob,
    input  logic [PREG_W-1:0] issue_pd,
    input  logic [XLEN-1:0]   issue_a,
    input  logic [XLEN-1:0]   issue_b,
    input  logic              flush,
    output logic              fu_ready,
    output logic              wb_valid,
    output logic [XLEN-1:0]   wb_data,
    output logic [ROB_W-1:0]  wb_rob,
    output logic [PREG_W-1:0] wb_pd,
    input  logic              wb_grant
);

    fu_state_t       state;
    fu_op_t          op;
    logic [4:0]      shamt;
    logic [XLEN-1:0] alu_res;
    logic            accept;
    logic            start_mul;

    assign op     = fu_op_t'(issue_op);
    assign shamt  = issue_b[4:0];
    // A granted DONE slot frees in the same cycle, allowing back-to-back issue.
    assign fu_ready = ((state == ST_IDLE) || ((state == ST_DONE) && wb_grant)) && !flush;
    assign accept   = issue_valid && fu_ready;

    always_comb begin
        alu_res = '0;
        case (op)
            FU_ADD:  alu_res = issue_a + issue_b;
            FU_SUB:  alu_res = issue_a - issue_b;
            FU_AND:  alu_res = issue_a & issue_b;
            FU_OR:   alu_res = issue_a | issue_b;
            FU_XOR:  alu_res = issue_a ^ issue_b;
            FU_SLL:  alu_res = issue_a << shamt;
            FU_SRL:  alu_res = issue_a >> shamt;
            FU_SRA:  alu_res = $signed(issue_a) >>> shamt;
            FU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(issue_a) < $signed(issue_b))};
            FU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (issue_a < issue_b)};
            default: alu_res = '0;
        endcase
    end

`ifdef MUL_ENABLE_EN
    logic            mul_done;
    logic [XLEN-1:0] mul_product;

    assign start_mul = accept && (op == FU_MUL);

    mul_iter #(.XLEN(XLEN)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (start_mul),
        .clear   (flush),
        .a       (issue_a),
        .b       (issue_b),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign start_mul = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            wb_valid <= 1'b0;
            wb_data  <= '0;
            wb_rob   <= '0;
            wb_pd    <= '0;
        end else if (flush) begin
            state    <= ST_IDLE;
            wb_valid <= 1'b0;
        end else if (accept) begin
            wb_rob <= issue_rob;
            wb_pd  <= issue_pd;
`ifdef MUL_ENABLE_EN
            if (start_mul) begin
                state    <= ST_MUL_BUSY;
                wb_valid <= 1'b0;
            end else begin
                state    <= ST_DONE;
                wb_valid <= 1'b1;
                wb_data  <= alu_res;
            end
`else
            state    <= ST_DONE;
            wb_valid <= 1'b1;
            wb_data  <= alu_res;
`endif
        end else begin
            case (state)
                ST_DONE: begin
                    if (wb_grant) begin
                        state    <= ST_IDLE;
                        wb_valid <= 1'b0;
                    end
                end
`ifdef MUL_ENABLE_EN
                ST_MUL_BUSY: begin
                    if (mul_done) begin
                        state    <= ST_DONE;
                        wb_valid <= 1'b1;
                        wb_data  <= mul_product;
                    end
                end
`endif
                default: state <= state;
            endcase
        end
    end

    logic unused_start;
    assign unused_start = start_mul;

endmodule

// File: tb/tb_exec_alu_fu.sv
// Directed and randomized checks of exec_alu_fu against an arithmetic reference model.
module tb_exec_alu_fu;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [3:0]  issue_op;
    logic [5:0]  issue_rob;
    logic [5:0]  issue_pd;
    logic [31:0] issue_a;
    logic [31:0] issue_b;
    logic        flush;
    logic        fu_ready;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [5:0]  wb_rob;
    logic [5:0]  wb_pd;
    logic        wb_grant;

    int n_checks = 0;
    int n_fail   = 0;

    exec_alu_fu dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_op    (issue_op),
        .issue_rob   (issue_rob),
        .issue_pd    (issue_pd),
        .issue_a     (issue_a),
        .issue_b     (issue_b),
        .flush       (flush),
        .fu_ready    (fu_ready),
        .wb_valid    (wb_valid),
        .wb_data     (wb_data),
        .wb_rob      (wb_rob),
        .wb_pd       (wb_pd),
        .wb_grant    (wb_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_model(input int op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        logic [63:0] prod;
        sh = b[4:0];
        prod = {32'd0, a} * {32'd0, b};
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return a & b;
            3:  return a | b;
            4:  return a ^ b;
            5:  return a << sh;
            6:  return a >> sh;
            7:  return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            9:  return (a < b) ? 32'd1 : 32'd0;
`ifdef MUL_ENABLE_EN
            10: return prod[31:0];
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [5:0] rob, input logic [5:0] pd);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_a     = a;
        issue_b     = b;
        issue_rob   = rob;
        issue_pd    = pd;
    endtask

    // Issue one op with grant held high; check the result and the drain back to idle.
    task automatic one_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        wb_grant = 1'b1;
        set_issue(op, a, b, 6'd1, 6'd2);
        tick();
        issue_valid = 1'b0;
        check({tag, "_valid"}, wb_valid, 1);
        check({tag, "_data"}, wb_data, ref_model(op, a, b));
        tick();
        check({tag, "_drain"}, wb_valid, 0);
        wb_grant = 1'b0;
    endtask

    initial begin
        int cycles;
        int seen;
        rst = 1'b1;
        issue_valid = 1'b0;
        issue_op = '0;
        issue_rob = '0;
        issue_pd = '0;
        issue_a = '0;
        issue_b = '0;
        flush = 1'b0;
        wb_grant = 1'b0;
        #2;
        check("rst_valid", wb_valid, 0);
        check("rst_data", wb_data, 0);
        check("rst_rob", wb_rob, 0);
        check("rst_pd", wb_pd, 0);
        check("rst_ready", fu_ready, 1);
        @(posedge clk);
        #1 rst = 1'b0;

        // ADD with immediate grant: one cycle result, idle the cycle after
        wb_grant = 1'b1;
        set_issue(4'd0, 32'd5, 32'd7, 6'd3, 6'd9);
        tick();
        issue_valid = 1'b0;
        check("add_valid", wb_valid, 1);
        check("add_data", wb_data, 32'd12);
        check("add_rob", wb_rob, 3);
        check("add_pd", wb_pd, 9);
        tick();
        check("add_idle", wb_valid, 0);
        check("add_ready", fu_ready, 1);
        wb_grant = 1'b0;

        one_op("sra", 4'd7, 32'h8000_0000, 32'd4);
        check("sra_const", ref_model(7, 32'h8000_0000, 32'd4), 32'hF800_0000);
        one_op("slt", 4'd8, 32'hFFFF_FFFF, 32'd1);
        one_op("sltu", 4'd9, 32'hFFFF_FFFF, 32'd1);
        one_op("undef", 4'd13, 32'h1234, 32'h5678);
        one_op("shamt", 4'd5, 32'h0000_0001, 32'hFFFF_FFFF);

        // SUB held without grant; issue attempts must be ignored
        set_issue(4'd1, 32'd10, 32'd3, 6'd5, 6'd6);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_issue(4'd0, 32'd100, 32'd100, 6'd7, 6'd8);
            #1;
            check("hold_ready", fu_ready, 0);
            tick();
            check("hold_valid", wb_valid, 1);
            check("hold_data", wb_data, 32'd7);
            check("hold_rob", wb_rob, 5);
        end
        issue_valid = 1'b0;
        wb_grant = 1'b1;
        #1;
        check("grant_ready", fu_ready, 1);
        tick();
        check("grant_drop", wb_valid, 0);
        wb_grant = 1'b0;

        // back-to-back: grant and new issue on the same edge
        set_issue(4'd0, 32'd3, 32'd4, 6'd10, 6'd11);
        tick();
        wb_grant = 1'b1;
        set_issue(4'd0, 32'd1, 32'd1, 6'd12, 6'd13);
        tick();
        issue_valid = 1'b0;
        check("b2b_valid", wb_valid, 1);
        check("b2b_data", wb_data, 32'd2);
        check("b2b_rob", wb_rob, 12);
        tick();
        check("b2b_idle", wb_valid, 0);
        wb_grant = 1'b0;

        // randomized ops with random grant delay
        for (int i = 0; i < 40; i++) begin
            logic [3:0]  op;
            logic [31:0] a, b, exp;
            logic [5:0]  rob, pd;
            int hold;
            op = 4'($urandom_range(0, 15));
`ifdef MUL_ENABLE_EN
            if (op == 4'd10) op = 4'd1;
`endif
            a = $urandom;
            b = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
            rob = 6'($urandom);
            pd = 6'($urandom);
            hold = $urandom_range(0, 2);
            exp = ref_model(op, a, b);
            set_issue(op, a, b, rob, pd);
            tick();
            issue_valid = 1'b0;
            check("rnd_valid", wb_valid, 1);
            check("rnd_data", wb_data, exp);
            check("rnd_rob", wb_rob, rob);
            check("rnd_pd", wb_pd, pd);
            for (int h = 0; h < hold; h++) begin
                set_issue(4'($urandom), $urandom, $urandom, 6'($urandom), 6'($urandom));
                tick();
                check("rnd_stable", wb_data, exp);
            end
            issue_valid = 1'b0;
            wb_grant = 1'b1;
            tick();
            check("rnd_drain", wb_valid, 0);
            wb_grant = 1'b0;
        end

`ifdef MUL_ENABLE_EN
        wb_grant = 1'b1;
        set_issue(4'd10, 32'd1234, 32'd5678, 6'd20, 6'd21);
        tick();
        issue_valid = 1'b0;
        cycles = 1;
        while (!wb_valid && cycles < 100) begin
            check("mul_busy_ready", fu_ready, 0);
            tick();
            cycles++;
        end
        check("mul_latency", cycles, 32);
        check("mul_data", wb_data, 32'd7006652);
        check("mul_rob", wb_rob, 20);
        tick();
        check("mul_drain", wb_valid, 0);

        set_issue(4'd10, 32'd1234, 32'd5678, 6'd22, 6'd23);
        tick();
        issue_valid = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        #1;
        check("mflush_ready", fu_ready, 0);
        tick();
        flush = 1'b0;
        check("mflush_valid", wb_valid, 0);
        seen = 0;
        repeat (40) begin
            tick();
            if (wb_valid) seen++;
        end
        check("mflush_never", seen, 0);
        check("mflush_idle", fu_ready, 1);
        wb_grant = 1'b0;
`else
        one_op("mul_off", 4'd10, 32'd1234, 32'd5678);
        cycles = 0;
        seen = 0;
        check("mul_off_zero", ref_model(10, 32'd1234, 32'd5678) + 32'(cycles + seen), 0);
`endif

        // flush in DONE with a same-cycle issue: both dropped
        set_issue(4'd0, 32'd9, 32'd9, 6'd30, 6'd31);
        tick();
        flush = 1'b1;
        wb_grant = 1'b1;
        set_issue(4'd0, 32'd1, 32'd1, 6'd1, 6'd1);
        #1;
        check("flush_ready", fu_ready, 0);
        tick();
        flush = 1'b0;
        issue_valid = 1'b0;
        check("flush_valid", wb_valid, 0);
        tick();
        check("flush_dropped", wb_valid, 0);
        wb_grant = 1'b0;

        // async reset while a result is pending
        set_issue(4'd0, 32'd2, 32'd2, 6'd4, 6'd5);
        tick();
        issue_valid = 1'b0;
        check("pre_rst_valid", wb_valid, 1);
        #1 rst = 1'b1;
        #1;
        check("arst_valid", wb_valid, 0);
        check("arst_data", wb_data, 0);
        check("arst_rob", wb_rob, 0);
        check("arst_pd", wb_pd, 0);
        check("arst_ready", fu_ready, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        check("post_rst_valid", wb_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
